// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at acceptance into shadow registers and committed after a fixed latency.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] sh_hi_q, sh_hi_d;
  logic [31:0] sh_lo_q, sh_lo_d;
  logic        sh_ok_q, sh_ok_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Arithmetic datapath, evaluated on the operands present in the acceptance cycle.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    b_zero    = (b == 32'd0);
    num       = a_neg ? (32'd0 - a) : a;
    den       = b_neg ? (32'd0 - b) : b;
    // Divide by zero never commits; a dummy divisor keeps the datapath X-free.
    if (b_zero) begin
      den = 32'd1;
    end
    uq  = num / den;
    ur  = num % den;
    quo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem = a_neg ? (32'd0 - ur) : ur;
  end

  // Handshake: req is a single-cycle valid from E. It is taken only while
  // IDLE (start = req & ~busy for ops 0..3); requests seen while BUSY are
  // dropped, so the hazard unit must stall on start|busy.
  assign start   = req & (state_q == IDLE) & ~op[2];
  assign busy    = (state_q == BUSY);
  assign rd_data = rd_sel ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_ok_d = sh_ok_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!op[2]) begin
            state_d = BUSY;
            if (op[1]) begin
              cnt_d   = DIV_N;
              sh_ok_d = ~b_zero;
              sh_hi_d = rem;
              sh_lo_d = quo;
            end else begin
              cnt_d   = MULT_N;
              sh_ok_d = 1'b1;
              sh_hi_d = op[0] ? prod_u[63:32] : prod_s[63:32];
              sh_lo_d = op[0] ? prod_u[31:0]  : prod_s[31:0];
            end
          end else if (op == 3'd4) begin
            hi_d = a;
          end else if (op == 3'd5) begin
            lo_d = a;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          if (sh_ok_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
      sh_ok_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_ok_q <= sh_ok_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline, beside the ALU.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- `rd_data` is the source of the MFHI/MFLO result, which the E-stage mux passes to the EX/MEM register.
- `busy` and `start` go to the hazard unit, which stalls D-stage MDU instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; legal range 1..255.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..255.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 immediately clears all state.
- req  input  1  valid, non-flushed MDU instruction in E this cycle.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved no-ops.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- rd_sel  input  1  read select: 0 gives LO, 1 gives HI.
- rd_data  output  32  combinational read; rd_sel ? HI : LO.
- busy  output  1  registered; high while a mult/div is in flight.
- start  output  1  combinational; req & ~busy & (op <= 3).
- hi  output  32  architectural HI register (debug/trace).
- lo  output  32  architectural LO register (debug/trace).

Behaviour:
- Reset (reset==0, asynchronous):
  - hi = lo = 0, busy = 0, counter = 0, shadow registers = 0, FSM = IDLE.
  - A reset in the middle of an operation aborts it; HI/LO are not written.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - On an edge with req=1 and op in 0..3, compute the 64-bit result into shadow registers sh_hi/sh_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES, set busy=1 and go to BUSY.
  - HI/LO are untouched at this edge.
- BUSY:
  - The counter decrements on every edge.
  - On the edge where the counter goes from 1 to 0: hi<=sh_hi, lo<=sh_lo, busy<=0, go to IDLE.
- Latency:
  - A request accepted at edge t0 keeps busy high for exactly N cycles and commits HI/LO at edge t0+N.
  - MFHI/MFLO see the new values from cycle t0+N onward.
- MTHI/MTLO: with req=1 in IDLE, hi<=a (op 4) or lo<=a (op 5) at the edge. There is no busy phase, and the value is readable in the next cycle.
- req while busy=1:
  - Ignored for every op, including MTHI/MTLO.
  - The hazard unit guarantees this never happens; the bench checks it as a robustness case.
- op 6/7 with req=1: no state change.
- MULT: signed 32x32 -> 64; HI = upper word, LO = lower word.
- MULTU: same as MULT, but unsigned.
- DIV (signed):
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (a).
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no trap.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b==0): still takes DIV_CYCLES with busy high, but the commit leaves HI/LO at their old values.
- start is high only in the acceptance cycle. busy is low in that cycle, so the hazard unit uses start|busy to stall.
- rd_data is purely combinational and never bypasses an in-flight result; the hazard unit must stall MFHI/MFLO while start|busy.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles, then release. Expect hi=lo=0, busy=0 and rd_data=0 for both rd_sel values.
- MULT signed:
  - Stimulus: a=0xFFFFFFFE (-2), b=0x00000003, req at edge t0.
  - Expect: busy high for exactly 5 cycles; at edge t0+5, hi=0xFFFFFFFF and lo=0xFFFFFFFA.
  - Expect: MULTU with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV:
  - a=-7 (0xFFFFFFF9), b=2 gives after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 gives lo=3, hi=1.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero:
  - First MTHI a=0x1234, then MTLO a=0x5678; expect each readable in the next cycle.
  - Then DIV with b=0; expect busy for 10 cycles and hi=0x1234, lo=0x5678 unchanged.
- Requests during busy: start a MULT, then drive MTLO and a DIVU during busy cycles 2 and 3. Expect both ignored and the MULT result committed alone at t0+5.
- Reset mid-operation: start a DIV, then pull reset low in busy cycle 4. Expect busy=0 and hi=lo=0 immediately (asynchronously), and no commit afterwards.
